exc_ctrl: RTL and testbench

Exception/interrupt controller that sits between the memory-stage pipeline register and CP0. It collects per-instruction exception flags and the pending-interrupt condition, then arbitrates them by fixed priority. It presents exactly one event to CP0 (EXcCode, Badaddr, DelaySlot, PC) and holds it across CP0's negative-edge update. It then stalls, flushes and redirects the pipeline to the exception vector or to EPC.

---
 rtl/exc_ctrl_pkg.sv | 54 +++++
 rtl/exc_prio_enc.sv | 45 ++++
 rtl/exc_ctrl.sv | 138 +++++++++++++
 tb/tb_exc_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: CP0 exception codes,
// controller state encoding, priority-encoder flag bundle and helpers.
package exc_ctrl_pkg;

    // CP0 ExcCode values (mirror the defines2.vh encoding used by CP0)
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;
    localparam logic [4:0] EXC_ERET = 5'h0E;

    // "No event" code: falls into CP0's default branch and is ignored
    localparam logic [4:0]  EXC_NONE_CODE   = 5'h1F;
    // Exception entry PC
    localparam logic [31:0] EXC_VECTOR_ADDR = 32'hBFC0_0380;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_REDIR = 2'd2
    } exc_state_t;

    // Source of the bad virtual address reported to CP0
    typedef enum logic [1:0] {
        BAD_ZERO  = 2'd0,
        BAD_PC    = 2'd1,
        BAD_DADDR = 2'd2
    } bad_sel_t;

    // Per-instruction exception flags from the memory stage
    typedef struct packed {
        logic adel_if;
        logic ri;
        logic sys;
        logic bp;
        logic ov;
        logic adel_ld;
        logic ades;
        logic eret;
    } exc_flags_t;

    // Interrupt pending: IE set, EXL clear, and some unmasked IP bit set
    function automatic logic int_pending(input logic       ie,
                                         input logic       exl,
                                         input logic [7:0] im,
                                         input logic [7:0] ip);
        return ie & ~exl & (|(im & ip));
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder: picks the single highest-priority event among the
// pending interrupt and the instruction's exception flags.
module exc_prio_enc
    import exc_ctrl_pkg::*;
(
    input  exc_flags_t  flags,
    input  logic        int_pend,
    output logic        valid,
    output logic [4:0]  code,
    output bad_sel_t    badaddr_sel
);

    // Priority chain, highest first; lower-priority flags are simply dropped
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        valid       = 1'b1;
        code        = EXC_NONE_CODE;
        badaddr_sel = BAD_ZERO;
        if (int_pend) begin
            code = EXC_INT;
        end else if (flags.adel_if) begin
            code        = EXC_ADEL;
            badaddr_sel = BAD_PC;
        end else if (flags.ri) begin
            code = EXC_RI;
        end else if (flags.sys) begin
            code = EXC_SYS;
        end else if (flags.bp) begin
            code = EXC_BP;
        end else if (flags.ov) begin
            code = EXC_OV;
        end else if (flags.adel_ld) begin
            code        = EXC_ADEL;
            badaddr_sel = BAD_DADDR;
        end else if (flags.ades) begin
            code        = EXC_ADES;
            badaddr_sel = BAD_DADDR;
        end else if (flags.eret) begin
            code = EXC_ERET;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller between the memory stage and CP0. Captures
// one event per instruction, holds it for CP0, then flushes and redirects.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_ADDR,
    parameter logic [4:0]  EXC_NONE   = EXC_NONE_CODE
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_in_ds,
    input  logic [31:0] m_daddr,
    input  logic        m_adel_if,
    input  logic        m_ri,
    input  logic        m_sys,
    input  logic        m_bp,
    input  logic        m_ov,
    input  logic        m_adel_ld,
    input  logic        m_ades,
    input  logic        m_eret,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    input  logic        cp0_except_deal,
    output logic [4:0]  cp0_exccode,
    output logic [31:0] cp0_badaddr,
    output logic        cp0_delayslot,
    output logic [31:0] cp0_pc,
    output logic        stall_out,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    exc_state_t  state, state_next;
    exc_flags_t  flags;
    logic        int_pend;
    logic        enc_valid;
    logic [4:0]  enc_code;
    bad_sel_t    enc_sel;
    logic [31:0] bad_next;
    logic [4:0]  code_q;
    logic        event_req;
    logic        unused_bits;

    // Only IE, EXL, IM and IP take part in the interrupt decision
    assign unused_bits = ^{cp0_status[31:16], cp0_status[7:2],
                           cp0_cause[31:16], cp0_cause[7:0]};

    assign int_pend = int_pending(cp0_status[0], cp0_status[1],
                                  cp0_status[15:8], cp0_cause[15:8]);

    assign flags = '{adel_if: m_adel_if, ri: m_ri, sys: m_sys, bp: m_bp,
                     ov: m_ov, adel_ld: m_adel_ld, ades: m_ades, eret: m_eret};

    exc_prio_enc u_prio (
        .flags       (flags),
        .int_pend    (int_pend),
        .valid       (enc_valid),
        .code        (enc_code),
        .badaddr_sel (enc_sel)
    );

    // An interrupt needs a valid instruction to carry EPC, so m_valid gates all
    assign event_req = m_valid & ~stall_in & enc_valid;

    // Bad virtual address source selected by the winning event
    always_comb begin
        case (enc_sel)
            BAD_PC:    bad_next = m_pc;
            BAD_DADDR: bad_next = m_daddr;
            default:   bad_next = 32'h0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic: capture in IDLE, wait for CP0 in HOLD, one REDIR cycle
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (event_req)       state_next = ST_HOLD;
            ST_HOLD:  if (cp0_except_deal) state_next = ST_REDIR;
            ST_REDIR: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output decode: CP0 sees a real code only while HOLD keeps it stable
    always_comb begin
        stall_out      = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        cp0_exccode    = EXC_NONE;
        case (state)
            ST_HOLD: begin
                stall_out   = 1'b1;
                cp0_exccode = code_q;
            end
            ST_REDIR: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Event payload captured on IDLE->HOLD; redirect target on HOLD->REDIR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q        <= EXC_NONE;
            cp0_badaddr   <= 32'h0;
            cp0_delayslot <= 1'b0;
            cp0_pc        <= 32'h0;
            redirect_pc   <= 32'h0;
        end else begin
            if (state == ST_IDLE && event_req) begin
                code_q        <= enc_code;
                cp0_badaddr   <= bad_next;
                cp0_delayslot <= m_in_ds;
                cp0_pc        <= m_pc;
            end
            // EPC is sampled live at this edge, after CP0 has settled
            if (state == ST_HOLD && cp0_except_deal) begin
                redirect_pc <= (code_q == EXC_ERET) ? cp0_epc : EXC_VECTOR;
            end
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: directed events push expected CP0 payloads
// and redirect targets; a monitor pops and compares when the DUT presents them.
module tb_exc_ctrl;

    localparam logic [31:0] VEC  = 32'hBFC0_0380;
    localparam logic [4:0]  NONE = 5'h1F;

    // flag vector bit order: {adel_if, ri, sys, bp, ov, adel_ld, ades, eret}
    localparam logic [7:0] F_ADEL_IF = 8'h80;
    localparam logic [7:0] F_RI      = 8'h40;
    localparam logic [7:0] F_SYS     = 8'h20;
    localparam logic [7:0] F_BP      = 8'h10;
    localparam logic [7:0] F_OV      = 8'h08;
    localparam logic [7:0] F_ADEL_LD = 8'h04;
    localparam logic [7:0] F_ADES    = 8'h02;
    localparam logic [7:0] F_ERET    = 8'h01;

    logic        clk, rst, stall_in, m_valid, m_in_ds, cp0_except_deal;
    logic [31:0] m_pc, m_daddr, cp0_status, cp0_cause, cp0_epc;
    logic [7:0]  fl;
    logic [4:0]  cp0_exccode;
    logic [31:0] cp0_badaddr, cp0_pc, redirect_pc;
    logic        cp0_delayslot, stall_out, flush, redirect_valid;

    typedef struct {
        logic [4:0]  code;
        logic [31:0] bad;
        logic        ds;
        logic [31:0] pc;
    } hold_exp_t;

    hold_exp_t   hold_q[$];
    logic [31:0] redir_q[$];
    int checks   = 0;
    int failures = 0;

    exc_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .stall_in        (stall_in),
        .m_valid         (m_valid),
        .m_pc            (m_pc),
        .m_in_ds         (m_in_ds),
        .m_daddr         (m_daddr),
        .m_adel_if       (fl[7]),
        .m_ri            (fl[6]),
        .m_sys           (fl[5]),
        .m_bp            (fl[4]),
        .m_ov            (fl[3]),
        .m_adel_ld       (fl[2]),
        .m_ades          (fl[1]),
        .m_eret          (fl[0]),
        .cp0_status      (cp0_status),
        .cp0_cause       (cp0_cause),
        .cp0_epc         (cp0_epc),
        .cp0_except_deal (cp0_except_deal),
        .cp0_exccode     (cp0_exccode),
        .cp0_badaddr     (cp0_badaddr),
        .cp0_delayslot   (cp0_delayslot),
        .cp0_pc          (cp0_pc),
        .stall_out       (stall_out),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=present expected=absent", name);
    endtask

    // Monitor: compare on HOLD entry (stall_out rising) and on each REDIR cycle
    initial begin
        logic      prev_stall;
        hold_exp_t e;
        logic [31:0] r;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (stall_out && !prev_stall) begin
                    if (hold_q.size() == 0) unexpected("hold_unexpected");
                    else begin
                        e = hold_q.pop_front();
                        check("hold_code", {27'b0, cp0_exccode}, {27'b0, e.code});
                        check("hold_badaddr", cp0_badaddr, e.bad);
                        check("hold_delayslot", {31'b0, cp0_delayslot}, {31'b0, e.ds});
                        check("hold_pc", cp0_pc, e.pc);
                    end
                end
                if (redirect_valid) begin
                    if (redir_q.size() == 0) unexpected("redir_unexpected");
                    else begin
                        r = redir_q.pop_front();
                        check("redir_pc", redirect_pc, r);
                        check("redir_flush", {31'b0, flush}, 32'd1);
                        check("redir_stall", {31'b0, stall_out}, 32'd0);
                        check("redir_code", {27'b0, cp0_exccode}, {27'b0, NONE});
                    end
                end
                prev_stall = stall_out;
            end
        end
    end

    // Present an instruction with flags (caller is at a negedge) and queue expectations
    task automatic start_event(input logic [7:0] f, input logic [31:0] pc, input logic [31:0] da,
                               input logic ds, input logic [4:0] code, input logic [31:0] bad,
                               input logic [31:0] rpc, input logic push_redir);
        m_valid = 1'b1;
        fl      = f;
        m_pc    = pc;
        m_daddr = da;
        m_in_ds = ds;
        hold_q.push_back('{code: code, bad: bad, ds: ds, pc: pc});
        if (push_redir) redir_q.push_back(rpc);
    endtask

    // Walk the event through HOLD (two cycles) -> ExceptDeal -> REDIR -> IDLE
    task automatic complete_event(input logic [31:0] epc_late, input logic stall_hold,
                                  input logic inject_redir);
        @(negedge clk);
        m_valid = 1'b0;
        fl      = 8'h00;
        check("hold_entry", {31'b0, stall_out}, 32'd1);
        check("hold_no_flush", {31'b0, flush}, 32'd0);
        stall_in = stall_hold;
        @(negedge clk);
        check("hold_wait", {31'b0, stall_out}, 32'd1);
        check("hold_no_redir", {31'b0, redirect_valid}, 32'd0);
        cp0_epc         = epc_late;
        cp0_except_deal = 1'b1;
        @(negedge clk);
        cp0_except_deal = 1'b0;
        stall_in        = 1'b0;
        check("redir_entry", {31'b0, redirect_valid}, 32'd1);
        if (inject_redir) begin
            m_valid = 1'b1;
            fl      = F_SYS;
        end
        @(negedge clk);
        m_valid = 1'b0;
        fl      = 8'h00;
        check("idle_stall", {31'b0, stall_out}, 32'd0);
        check("idle_redir", {31'b0, redirect_valid}, 32'd0);
        check("idle_code", {27'b0, cp0_exccode}, {27'b0, NONE});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_code"},   {27'b0, cp0_exccode},    {27'b0, NONE});
        check({tag, "_bad"},    cp0_badaddr,             32'h0);
        check({tag, "_ds"},     {31'b0, cp0_delayslot},  32'd0);
        check({tag, "_pc"},     cp0_pc,                  32'h0);
        check({tag, "_stall"},  {31'b0, stall_out},      32'd0);
        check({tag, "_flush"},  {31'b0, flush},          32'd0);
        check({tag, "_rv"},     {31'b0, redirect_valid}, 32'd0);
        check({tag, "_rpc"},    redirect_pc,             32'h0);
    endtask

    initial begin
        rst = 1'b1; stall_in = 1'b0; m_valid = 1'b0; m_in_ds = 1'b0; fl = 8'h00;
        m_pc = 32'h0; m_daddr = 32'h0; cp0_status = 32'h0; cp0_cause = 32'h0;
        cp0_epc = 32'h0; cp0_except_deal = 1'b0;
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Overflow: code 12, vector redirect
        start_event(F_OV, 32'h8000_0100, 32'h0, 1'b0, 5'd12, 32'h0, VEC, 1'b1);
        complete_event(32'h0, 1'b0, 1'b0);

        // AdES in a delay slot: badaddr from data address; stall_in ignored in HOLD
        @(negedge clk);
        start_event(F_ADES, 32'h8000_0204, 32'h0000_0003, 1'b1, 5'd5, 32'h3, VEC, 1'b1);
        complete_event(32'h0, 1'b1, 1'b0);

        // ERET: redirect uses EPC as it stands at the HOLD->REDIR edge
        @(negedge clk);
        cp0_epc = 32'h0000_1111;
        start_event(F_ERET, 32'h8000_0300, 32'h0, 1'b0, 5'h0E, 32'h0, 32'h8000_2000, 1'b1);
        complete_event(32'h8000_2000, 1'b0, 1'b0);
        cp0_epc = 32'h0;

        // Interrupt beats RI
        @(negedge clk);
        cp0_status = 32'h0000_0401;
        cp0_cause  = 32'h0000_0400;
        start_event(F_RI, 32'h8000_0400, 32'h0, 1'b0, 5'd0, 32'h0, VEC, 1'b1);
        complete_event(32'h0, 1'b0, 1'b0);

        // Interrupt with EXL set is not pending: no event on a clean instruction
        @(negedge clk);
        cp0_status = 32'h0000_0403;
        m_valid    = 1'b1;
        @(negedge clk);
        check("exl_masks_int", {31'b0, stall_out}, 32'd0);
        m_valid = 1'b0;

        // Interrupt waits for a valid instruction, then carries its PC
        cp0_status = 32'h0000_0401;
        repeat (2) begin
            @(negedge clk);
            check("int_waits_valid", {31'b0, stall_out}, 32'd0);
        end
        start_event(8'h00, 32'h8000_0600, 32'h0, 1'b1, 5'd0, 32'h0, VEC, 1'b1);
        complete_event(32'h0, 1'b0, 1'b0);
        cp0_status = 32'h0;
        cp0_cause  = 32'h0;

        // Fetch AdEL outranks Ov and AdES; badaddr is the PC
        @(negedge clk);
        start_event(F_ADEL_IF | F_OV | F_ADES, 32'h8000_0501, 32'h77, 1'b0, 5'd4, 32'h8000_0501, VEC, 1'b1);
        complete_event(32'h0, 1'b0, 1'b0);

        // Load AdEL outranks AdES; badaddr is the data address
        @(negedge clk);
        start_event(F_ADEL_LD | F_ADES, 32'h8000_0510, 32'h0000_1001, 1'b0, 5'd4, 32'h0000_1001, VEC, 1'b1);
        complete_event(32'h0, 1'b0, 1'b0);

        // RI over Sys, Sys over Bp, Bp alone, Ov over ERET (vector, not EPC)
        @(negedge clk);
        start_event(F_RI | F_SYS, 32'h8000_0520, 32'h0, 1'b0, 5'd10, 32'h0, VEC, 1'b1);
        complete_event(32'h0, 1'b0, 1'b0);
        @(negedge clk);
        start_event(F_SYS | F_BP, 32'h8000_0524, 32'h0, 1'b0, 5'd8, 32'h0, VEC, 1'b1);
        complete_event(32'h0, 1'b0, 1'b0);
        @(negedge clk);
        start_event(F_BP, 32'h8000_0528, 32'h0, 1'b1, 5'd9, 32'h0, VEC, 1'b1);
        complete_event(32'h0, 1'b0, 1'b0);
        @(negedge clk);
        cp0_epc = 32'h8000_9000;
        start_event(F_OV | F_ERET, 32'h8000_052C, 32'h0, 1'b0, 5'd12, 32'h0, VEC, 1'b1);
        complete_event(32'h8000_9000, 1'b0, 1'b0);
        cp0_epc = 32'h0;

        // Syscall under stall_in for 3 cycles: captured only after release;
        // a flagged instruction during REDIR is dropped
        @(negedge clk);
        m_valid  = 1'b1;
        fl       = F_SYS;
        m_pc     = 32'h8000_0800;
        stall_in = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_no_capture", {31'b0, stall_out}, 32'd0);
        end
        stall_in = 1'b0;
        start_event(F_SYS, 32'h8000_0800, 32'h0, 1'b0, 5'd8, 32'h0, VEC, 1'b1);
        complete_event(32'h0, 1'b0, 1'b1);

        // Reset in HOLD: outputs return at once and no redirect follows
        @(negedge clk);
        start_event(F_SYS, 32'h8000_0700, 32'h0, 1'b0, 5'd8, 32'h0, VEC, 1'b0);
        @(negedge clk);
        m_valid = 1'b0;
        fl      = 8'h00;
        check("rst_hold_entry", {31'b0, stall_out}, 32'd1);
        #2;
        rst             = 1'b1;
        cp0_except_deal = 1'b1;
        #1;
        check_reset_outputs("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cp0_except_deal = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_no_redir", {31'b0, redirect_valid}, 32'd0);
        end

        repeat (2) @(negedge clk);
        check("hold_q_drained", hold_q.size(), 32'd0);
        check("redir_q_drained", redir_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
